// File: rtl/lab4_branch_pht_sched.sv
// Arbitrates one single-port PHT between fetch-side lookups and execute-side
// counter updates. It also sweeps the whole table to zero after reset or flush.
module lab4_branch_pht_sched #(
    parameter int p_num_entries = 1024,
    parameter int p_qdepth      = 2,
    localparam int idx_bits     = $clog2(p_num_entries)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pred_req_val,
    output logic                pred_req_rdy,
    input  logic [31:0]         pred_req_pc,
    output logic                pred_resp_taken,
    input  logic                upd_val,
    output logic                upd_rdy,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic                flush,
    output logic                busy,
    output logic [idx_bits-1:0] pht_addr,
    output logic                pht_wen,
    output logic [1:0]          pht_wdata,
    input  logic [1:0]          pht_rdata
);

    localparam int qptr_bits = $clog2(p_qdepth);
    localparam logic [idx_bits-1:0] last_idx = idx_bits'(p_num_entries - 1);
    localparam logic [qptr_bits:0]  full_cnt = (qptr_bits + 1)'(p_qdepth);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    logic [idx_bits-1:0]   clear_ptr;
    logic [idx_bits-1:0]   q_idx   [p_qdepth];
    logic                  q_taken [p_qdepth];
    logic [qptr_bits-1:0]  q_head;
    logic [qptr_bits-1:0]  q_tail;
    logic [qptr_bits:0]    q_count;

    logic [idx_bits-1:0]   pred_idx;
    logic [idx_bits-1:0]   upd_idx;
    logic                  in_run;
    logic                  q_full;
    logic                  q_empty;
    logic                  do_drain;
    logic                  do_lookup;
    logic                  do_enq;
    logic [1:0]            drain_cnt;
    logic                  unused_pc_bits;

    assign pred_idx       = pred_req_pc[idx_bits+1:2];
    assign upd_idx        = upd_pc[idx_bits+1:2];
    assign unused_pc_bits = ^{pred_req_pc[31:idx_bits+2], pred_req_pc[1:0],
                              upd_pc[31:idx_bits+2], upd_pc[1:0]};

    assign in_run       = !reset && (state == RUN);
    assign q_full       = (q_count == full_cnt);
    assign q_empty      = (q_count == '0);
    assign busy         = !in_run;
    assign upd_rdy      = in_run && !q_full;
    assign pred_req_rdy = in_run && !q_full;
    assign do_enq       = upd_val && upd_rdy;

    // A full queue steals the port from fetch so updates can never starve.
    assign do_drain  = in_run && (q_full || (!pred_req_val && !q_empty));
    assign do_lookup = in_run && !q_full && pred_req_val;

    always_comb begin
        drain_cnt = pht_rdata;
        if (q_taken[q_head]) begin
            if (pht_rdata != 2'b11) drain_cnt = pht_rdata + 2'd1;
        end else begin
            if (pht_rdata != 2'b00) drain_cnt = pht_rdata - 2'd1;
        end
    end

    always_comb begin
        pht_addr        = '0;
        pht_wen         = 1'b0;
        pht_wdata       = 2'b00;
        pred_resp_taken = 1'b0;
        if (!reset && state == CLEAR) begin
            pht_addr = clear_ptr;
            pht_wen  = 1'b1;
        end else if (do_drain) begin
            pht_addr  = q_idx[q_head];
            pht_wen   = 1'b1;
            pht_wdata = drain_cnt;
        end else if (do_lookup) begin
            pht_addr        = pred_idx;
            pred_resp_taken = pht_rdata[1];
        end
    end

    // Flush shares the reset path: anything enqueued in the flush cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            q_count   <= '0;
        end else begin
            if (state == CLEAR) begin
                clear_ptr <= clear_ptr + idx_bits'(1);
                if (clear_ptr == last_idx) state <= RUN;
            end
            if (do_enq) q_tail <= q_tail + qptr_bits'(1);
            if (do_drain) q_head <= q_head + qptr_bits'(1);
            if (do_enq && !do_drain) begin
                q_count <= q_count + (qptr_bits + 1)'(1);
            end else if (!do_enq && do_drain) begin
                q_count <= q_count - (qptr_bits + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            q_idx[q_tail]   <= upd_idx;
            q_taken[q_tail] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_lab4_branch_pht_sched.sv
// Directed and random stimulus for the PHT scheduler, checked every cycle against
// a queue-based behavioural model of the table and the update buffer.
module tb_lab4_branch_pht_sched;

    localparam int NE = 16;
    localparam int QD = 2;

    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    logic        clk;
    logic        reset;
    logic        pred_req_val;
    logic        pred_req_rdy;
    logic [31:0] pred_req_pc;
    logic        pred_resp_taken;
    logic        upd_val;
    logic        upd_rdy;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
    logic        busy;
    logic [3:0]  pht_addr;
    logic        pht_wen;
    logic [1:0]  pht_wdata;
    logic [1:0]  pht_rdata;

    logic [1:0]  pht_mem [NE];

    int   n_assert = 0;
    int   n_fail   = 0;
    upd_t m_q[$];
    int   m_pht[NE];
    bit   m_clearing;
    int   m_clr;
    int   exp_w[4];
    int   exp_p[4];

    lab4_branch_pht_sched #(
        .p_num_entries (NE),
        .p_qdepth      (QD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pred_req_val    (pred_req_val),
        .pred_req_rdy    (pred_req_rdy),
        .pred_req_pc     (pred_req_pc),
        .pred_resp_taken (pred_resp_taken),
        .upd_val         (upd_val),
        .upd_rdy         (upd_rdy),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .flush           (flush),
        .busy            (busy),
        .pht_addr        (pht_addr),
        .pht_wen         (pht_wen),
        .pht_wdata       (pht_wdata),
        .pht_rdata       (pht_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pht_rdata = pht_mem[pht_addr];

    always_ff @(posedge clk) begin
        if (pht_wen) pht_mem[pht_addr] <= pht_wdata;
    end

    function automatic int sat(input int c, input bit t);
        if (t) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic pv,
                                 input logic [31:0] ppc, input logic uv,
                                 input logic [31:0] upc, input logic ut);
        @(posedge clk);
        #1;
        reset        = rst;
        flush        = fl;
        pred_req_val = pv;
        pred_req_pc  = ppc;
        upd_val      = uv;
        upd_pc       = upc;
        upd_taken    = ut;
    endtask

    // Compares this cycle's outputs with the model, then advances the model.
    task automatic checkOutput();
        bit   full;
        int   pidx;
        int   nv;
        upd_t e;
        @(negedge clk);
        if (reset) begin
            chk("rst_rdy", pred_req_rdy, 0);
            chk("rst_urdy", upd_rdy, 0);
            chk("rst_busy", busy, 1);
            chk("rst_wen", pht_wen, 0);
            chk("rst_addr", pht_addr, 0);
            chk("rst_wdata", pht_wdata, 0);
            chk("rst_resp", pred_resp_taken, 0);
            m_clearing = 1;
            m_clr      = 0;
            m_q.delete();
        end else if (m_clearing) begin
            chk("clr_busy", busy, 1);
            chk("clr_rdy", pred_req_rdy, 0);
            chk("clr_urdy", upd_rdy, 0);
            chk("clr_resp", pred_resp_taken, 0);
            chk("clr_wen", pht_wen, 1);
            chk("clr_addr", pht_addr, m_clr);
            chk("clr_wdata", pht_wdata, 0);
            m_pht[m_clr] = 0;
            m_clr++;
            if (m_clr == NE) m_clearing = 0;
            if (flush) begin
                m_clearing = 1;
                m_clr      = 0;
                m_q.delete();
            end
        end else begin
            full = (m_q.size() == QD);
            chk("run_busy", busy, 0);
            chk("run_rdy", pred_req_rdy, !full);
            chk("run_urdy", upd_rdy, !full);
            if (full || (!pred_req_val && m_q.size() != 0)) begin
                e  = m_q.pop_front();
                nv = sat(m_pht[e.idx], e.taken);
                chk("drn_wen", pht_wen, 1);
                chk("drn_addr", pht_addr, e.idx);
                chk("drn_wdata", pht_wdata, nv);
                m_pht[e.idx] = nv;
            end else if (pred_req_val) begin
                pidx = int'((pred_req_pc >> 2) % NE);
                chk("lkp_wen", pht_wen, 0);
                chk("lkp_addr", pht_addr, pidx);
                chk("lkp_resp", pred_resp_taken, (m_pht[pidx] >= 2) ? 1 : 0);
            end else begin
                chk("idle_wen", pht_wen, 0);
                chk("idle_addr", pht_addr, 0);
            end
            if (upd_val && !full) begin
                e.idx   = int'((upd_pc >> 2) % NE);
                e.taken = upd_taken;
                m_q.push_back(e);
            end
            if (flush) begin
                m_clearing = 1;
                m_clr      = 0;
                m_q.delete();
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic fl, input logic pv,
                         input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic ut);
        applyStimulus(rst, fl, pv, ppc, uv, upc, ut);
        checkOutput();
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        pred_req_val = 1'b0;
        pred_req_pc  = '0;
        upd_val      = 1'b0;
        upd_pc       = '0;
        upd_taken    = 1'b0;
        m_clearing   = 1;
        m_clr        = 0;
        for (int i = 0; i < NE; i++) m_pht[i] = 0;
        exp_w = '{2, 1, 0, 0};
        exp_p = '{1, 0, 0, 0};

        $display("[TB] reset and initial clear sweep");
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NE; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("s1_addr", pht_addr, i);
            chk("s1_busy", busy, 1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s1_done_busy", busy, 0);
        chk("s1_done_rdy", pred_req_rdy, 1);
        chk("s1_done_urdy", upd_rdy, 1);

        $display("[TB] taken updates saturate upward");
        cycle(0, 0, 1, 32'h0C, 0, 0, 0);
        chk("s2_pred0", pred_resp_taken, 0);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 0, 1, 32'h0C, 1);
            chk("s2_acc_nowr", pht_wen, 0);
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("s2_waddr", pht_addr, 3);
            chk("s2_wdata", pht_wdata, k);
        end
        cycle(0, 0, 1, 32'h0C, 0, 0, 0);
        chk("s2_pred1", pred_resp_taken, 1);
        chk("s2_pht3", pht_mem[3], 3);

        $display("[TB] not-taken updates saturate downward");
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 1, 32'h0C, 0);
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("s3_wdata", pht_wdata, exp_w[k]);
            cycle(0, 0, 1, 32'h0C, 0, 0, 0);
            chk("s3_pred", pred_resp_taken, exp_p[k]);
        end

        $display("[TB] full queue preempts predictions");
        cycle(0, 0, 1, 32'h10, 1, 32'h04, 1);
        chk("s4_rdy_a", pred_req_rdy, 1);
        cycle(0, 0, 1, 32'h10, 1, 32'h08, 1);
        chk("s4_urdy_b", upd_rdy, 1);
        chk("s4_wen_b", pht_wen, 0);
        cycle(0, 0, 1, 32'h10, 0, 0, 0);
        chk("s4_full_rdy", pred_req_rdy, 0);
        chk("s4_full_urdy", upd_rdy, 0);
        chk("s4_full_addr", pht_addr, 1);
        chk("s4_full_wdata", pht_wdata, 1);
        cycle(0, 0, 1, 32'h10, 0, 0, 0);
        chk("s4_serve_rdy", pred_req_rdy, 1);
        chk("s4_serve_addr", pht_addr, 4);
        cycle(0, 0, 1, 32'h10, 0, 0, 0);
        chk("s4_hold_wen", pht_wen, 0);
        chk("s4_pht2_old", pht_mem[2], 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s4_drain_addr", pht_addr, 2);
        chk("s4_drain_wdata", pht_wdata, 1);

        $display("[TB] flush discards pending update");
        cycle(0, 0, 1, 32'h10, 1, 32'h14, 1);
        cycle(0, 1, 1, 32'h10, 0, 0, 0);
        chk("s5_flushcyc_wen", pht_wen, 0);
        for (int i = 0; i < NE; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("s5_addr", pht_addr, i);
            chk("s5_busy", busy, 1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s5_done_busy", busy, 0);
        chk("s5_no_stale", pht_wen, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s5_pht5", pht_mem[5], 0);
        chk("s5_pht1", pht_mem[1], 0);

        $display("[TB] reset in the middle of a sweep");
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("s6_pre_addr", pht_addr, i);
        end
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("s6_rst_wen", pht_wen, 0);
        for (int i = 0; i < NE; i++) begin
            cycle(0, 0, 0, 0, 1, 32'h20, 1);
            chk("s6_addr", pht_addr, i);
            chk("s6_urdy", upd_rdy, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("s6_done_busy", busy, 0);
        chk("s6_done_wen", pht_wen, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 6), $urandom(),
                  ($urandom_range(0, 9) < 5), $urandom(), $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lab4_branch_pht_sched.md
Name: lab4_branch_pht_sched

Overview:
Scheduler that shares one single-port pattern history table (PHT) of 2-bit saturating counters between two requesters. The fetch side sends prediction lookups; the execute side sends branch-outcome updates.
Updates are buffered in a small queue and applied as one-cycle read-modify-writes. The block also sequences a full-table clear after reset and on flush.
It sits between the fetch/execute stages and the PHT register file used by the bimodal predictor.

Parameters:
p_num_entries, 1024, number of PHT entries (power of 2, >= 4); idx_bits = log2(p_num_entries)
p_qdepth, 2, update queue depth (power of 2, >= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pred_req_val  input  1  prediction request valid
pred_req_rdy  output  1  prediction request accepted this cycle when val && rdy
pred_req_pc  input  32  PC of branch to predict
pred_resp_taken  output  1  prediction result, meaningful in the cycle val && rdy
upd_val  input  1  update request valid
upd_rdy  output  1  update queue can accept
upd_pc  input  32  PC of resolved branch
upd_taken  input  1  resolved direction
flush  input  1  clear PHT and discard queued updates
busy  output  1  table clear in progress
pht_addr  output  idx_bits  PHT index
pht_wen  output  1  PHT write enable
pht_wdata  output  2  PHT write data
pht_rdata  input  2  PHT combinational read data at pht_addr

Behaviour:
- Index: idx = pc[idx_bits+1:2] for both requesters.
- States: CLEAR, RUN.
- Reset while asserted: state=CLEAR, clear_ptr=0, queue emptied. Outputs: pred_req_rdy=0, upd_rdy=0, busy=1, pht_wen=0, pht_addr=0, pht_wdata=00, pred_resp_taken=0.

CLEAR state:
- Each cycle: pht_addr=clear_ptr, pht_wen=1, pht_wdata=00, then clear_ptr++.
- After writing entry p_num_entries-1, go to RUN next cycle.
- Clear lasts exactly p_num_entries cycles.
- During CLEAR: busy=1, pred_req_rdy=0, upd_rdy=0, pred_resp_taken=0.

RUN state:
- busy=0.
- upd_rdy = !q_full.
- pred_req_rdy = !q_full. This is independent of pred_req_val.
- Per-cycle priority:
  1. q_full: drain queue head; no prediction served.
  2. else pred_req_val: lookup with pht_addr=pred idx, pht_wen=0, pred_resp_taken=pht_rdata[1]; queue holds.
  3. else queue non-empty: drain head.
  4. else idle: pht_wen=0, pht_addr=0.
- Drain: pht_addr=head idx, pht_wen=1, pht_wdata=sat(pht_rdata, taken), pop head.
- sat: taken gives min(cnt+1, 11); not-taken gives max(cnt-1, 00).
- Enqueue when upd_val && upd_rdy; entry stores {idx, taken}, FIFO order.
- Enqueue and drain in the same cycle are legal (occupancy unchanged).
- An accepted update is written no earlier than the next cycle. No bypass: a prediction to an index with a pending update reads the old counter.
- Queue pointers wrap modulo p_qdepth; occupancy counter is log2(p_qdepth)+1 bits.

flush:
- Sampled in RUN or CLEAR when reset=0.
- Next cycle: state=CLEAR, clear_ptr=0, queue emptied.
- In the flush cycle itself, normal RUN/CLEAR actions occur. An update enqueued that cycle is discarded.
- flush during CLEAR restarts the sweep from 0.
- Reset mid-CLEAR or mid-RUN: restart CLEAR from 0 and discard queue. Reset has priority over flush.

Test Plan:
(Bench instantiates p_num_entries=16, p_qdepth=2; PHT modelled as a 16x2 regfile.)
1. Reset 1 cycle then release -> busy=1 and pht_wen=1 for 16 cycles, pht_addr 0..15, wdata 00; cycle 17: busy=0, pred_req_rdy=1, upd_rdy=1.
2. Predict pc=0x0C (idx 3) -> pred_resp_taken=0. Then three separate taken updates to 0x0C with no predicts -> PHT[3] goes 01, 10, 11, each written the cycle after acceptance. Predict 0x0C -> 1.
3. From PHT[3]=11, four not-taken updates -> PHT[3] = 10, 01, 00, 00. Predictions after each write = 1, 0, 0, 0.
4. pred_req_val held high with pc=0x10; two updates (0x04 taken, 0x08 taken) accepted on consecutive cycles -> queue full.
   - Next cycle: pred_req_rdy=0, upd_rdy=0, PHT[1] written 01.
   - Following cycle: prediction served (rdy=1), queue at 1.
   - PHT[2] written 01 only once predictions stop or the queue refills.
5. Enqueue update 0x14 taken while predicts keep it queued, then pulse flush -> update discarded, 16-cycle clear, PHT[5]=00 afterward, busy deasserts on cycle 17.
6. Assert reset at clear cycle 5 (addr 4) -> next sweep starts at addr 0 and runs a full 16 cycles; an upd_val during CLEAR sees upd_rdy=0 throughout.
